ps2_keyboard_tx: RTL

PS2_KEYBOARD_TX -- requirements
Module: ps2_keyboard_tx

---
 rtl/ps2_keyboard_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: an 8-deep scan-code FIFO feeding an 11-bit
// frame serializer (start, d0..d7, odd parity, stop) with a generated ps2_clk.
module ps2_keyboard_tx #(
  parameter int CLK_HALF = 50,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       wr_n,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [9:0] HALF_LOAD = 10'(CLK_HALF - 1);
  // The inter-frame gap is counted in half-periods so the half-period counter never exceeds 10 bits.
  localparam logic [7:0] GAP_LAST  = 8'((GAP_BITS > 0) ? 2 * GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

  state_t      state, state_nx;
  logic [9:0]  half_cnt, half_cnt_nx;
  logic [7:0]  bit_cnt, bit_cnt_nx;
  logic [10:0] shreg, shreg_nx;
  logic        ps2_clk_nx, ps2_data_nx;

  logic [7:0]  mem [8];
  logic [2:0]  w_ptr, r_ptr;
  logic [3:0]  count;
  logic        push, pop, half_done;

  assign full      = (count == 4'd8);
  assign busy      = (state != IDLE);
  assign push      = ~wr_n & ~full;
  assign pop       = (state == LOAD);
  assign half_done = (half_cnt == 10'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_ptr    <= 3'd0;
      r_ptr    <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) w_ptr <= w_ptr + 3'd1;
      if (pop)  r_ptr <= r_ptr + 3'd1;
      if (push && !pop)      count <= count + 4'd1;
      else if (!push && pop) count <= count - 4'd1;
      if (!wr_n && full) overflow <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; emptying is done by clearing count, which keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (resetn && push) mem[w_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      half_cnt <= 10'd0;
      bit_cnt  <= 8'd0;
      shreg    <= 11'h7FF;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed below.
      state    <= state_nx;
      half_cnt <= half_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      ps2_clk  <= ps2_clk_nx;
      ps2_data <= ps2_data_nx;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path through the case infers a latch.
    state_nx    = state;
    half_cnt_nx = half_cnt;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    ps2_clk_nx  = ps2_clk;
    ps2_data_nx = ps2_data;
    unique case (state)
      IDLE: begin
        ps2_clk_nx  = 1'b1;
        ps2_data_nx = 1'b1;
        half_cnt_nx = 10'd0;
        bit_cnt_nx  = 8'd0;
        if (count != 4'd0) state_nx = LOAD;
      end
      LOAD: begin
        shreg_nx    = {1'b1, ~^mem[r_ptr], mem[r_ptr], 1'b0};
        bit_cnt_nx  = 8'd0;
        ps2_clk_nx  = 1'b1;
        ps2_data_nx = 1'b0;
        half_cnt_nx = HALF_LOAD;
        state_nx    = BIT_HI;
      end
      BIT_HI: begin
        if (half_done) begin
          ps2_clk_nx  = 1'b0;
          half_cnt_nx = HALF_LOAD;
          state_nx    = BIT_LO;
        end else begin
          half_cnt_nx = half_cnt - 10'd1;
        end
      end
      BIT_LO: begin
        if (half_done) begin
          ps2_clk_nx  = 1'b1;
          half_cnt_nx = HALF_LOAD;
          if (bit_cnt < 8'd10) begin
            // Data changes together with the rising edge, a full half-period before the next fall.
            shreg_nx    = {1'b1, shreg[10:1]};
            ps2_data_nx = shreg[1];
            bit_cnt_nx  = bit_cnt + 8'd1;
            state_nx    = BIT_HI;
          end else begin
            ps2_data_nx = 1'b1;
            bit_cnt_nx  = 8'd0;
            state_nx    = GAP;
          end
        end else begin
          half_cnt_nx = half_cnt - 10'd1;
        end
      end
      GAP: begin
        if (half_done) begin
          half_cnt_nx = HALF_LOAD;
          if (bit_cnt == GAP_LAST) state_nx = IDLE;
          else bit_cnt_nx = bit_cnt + 8'd1;
        end else begin
          half_cnt_nx = half_cnt - 10'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
